// File: rtl/vx_raster_stamp_queue_pkg.sv
// Shared types and constants for the per-warp raster stamp queue.
// A stamp is stored in its CSR view: the packed pos/mask word followed by the barycentric words.
package vx_raster_stamp_queue_pkg;

  localparam int XLEN                     = 32;
  localparam int UUID_WIDTH               = 44;
  localparam int CSR_ADDR_BITS            = 12;
  localparam int RASTER_DIM_BITS          = 15;
  localparam int RASTER_CSR_COUNT         = 16;
  localparam int RASTER_CSR_SEL_BITS      = $clog2(RASTER_CSR_COUNT);
  localparam int RASTER_STAMP_QUEUE_DEPTH = 2;

  typedef struct packed {
    logic [RASTER_DIM_BITS-2:0] pos_y;
    logic [RASTER_DIM_BITS-2:0] pos_x;
    logic [3:0]                 mask;
    logic [2:0][3:0][31:0]      bcoords;
  } raster_stamp_t;

  typedef struct packed {
    logic [31:0]           pos_mask;
    logic [2:0][3:0][31:0] bcoords;
  } raster_csrs_t;

  function automatic int log2up(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic raster_csrs_t to_csrs(input raster_stamp_t s);
    raster_csrs_t c;
    c.pos_mask = {s.pos_y, s.pos_x, s.mask};
    c.bcoords  = s.bcoords;
    return c;
  endfunction

  // Word 0 is pos_mask; word 1+4*c+q is bcoords[c][q]; the remaining words read as zero.
  function automatic logic [31:0] csr_word(input raster_csrs_t c,
                                           input logic [RASTER_CSR_SEL_BITS-1:0] sel);
    logic [31:0] w;
    w = '0;
    if (sel == '0) w = c.pos_mask;
    for (int k = 0; k < 12; k++) begin
      if (int'(sel) == k + 1) w = c.bcoords[k / 4][k % 4];
    end
    return w;
  endfunction

endpackage

// File: rtl/vx_raster_stamp_queue_ptrs.sv
// Head/tail/count bookkeeping for one warp's ring of stamp slots.
// A pop on an empty ring is dropped here so callers need not guard it.
module vx_raster_stamp_queue_ptrs
  import vx_raster_stamp_queue_pkg::*;
#(
  parameter int DEPTH  = RASTER_STAMP_QUEUE_DEPTH,
  parameter int SLOT_W = log2up(DEPTH),
  parameter int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              commit,
  input  logic              pop,
  output logic [SLOT_W-1:0] head,
  output logic [SLOT_W-1:0] tail,
  output logic              pending,
  output logic              full
);

  logic [SLOT_W-1:0] head_reg, head_next;
  logic [SLOT_W-1:0] tail_reg, tail_next;
  logic [CNT_W-1:0]  count_reg, count_next;
  logic              pop_ok;

  assign pop_ok = pop && (count_reg != '0);

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_comb begin
    head_next  = head_reg;
    tail_next  = tail_reg;
    if (pop_ok) head_next = (DEPTH == 1) ? '0 : head_reg + SLOT_W'(1);
    if (commit) tail_next = (DEPTH == 1) ? '0 : tail_reg + SLOT_W'(1);
    count_next = count_reg + CNT_W'(commit) - CNT_W'(pop_ok);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      head_reg  <= head_next;
      tail_reg  <= tail_next;
      count_reg <= count_next;
    end
  end

  assign head    = head_reg;
  assign tail    = tail_reg;
  assign pending = (count_reg != '0);
  assign full    = (count_reg == CNT_W'(DEPTH));

endmodule

// File: rtl/vx_raster_stamp_queue.sv
// Per-core raster stamp buffer: per-warp queue of DEPTH stamp slots, filled packet by packet
// and read at the head slot through the flattened SFU CSR read port.
module vx_raster_stamp_queue
  import vx_raster_stamp_queue_pkg::*;
#(
  parameter int CORE_ID     = 0,
  parameter int NUM_LANES   = 1,
  parameter int NUM_WARPS   = 4,
  parameter int NUM_THREADS = 4,
  parameter int DEPTH       = RASTER_STAMP_QUEUE_DEPTH,
  parameter int PID_WIDTH   = log2up(NUM_THREADS / NUM_LANES),
  parameter int NW_WIDTH    = log2up(NUM_WARPS)
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                write_valid,
  output logic                                write_ready,
  input  logic [UUID_WIDTH-1:0]               write_uuid,
  input  logic [NW_WIDTH-1:0]                 write_wid,
  input  logic [PID_WIDTH-1:0]                write_pid,
  input  logic [NUM_LANES-1:0]                write_tmask,
  input  raster_stamp_t [NUM_LANES-1:0]       write_data,
  input  logic                                write_last,
  input  logic                                pop_valid,
  input  logic [NW_WIDTH-1:0]                 pop_wid,
  output logic [NUM_WARPS-1:0]                warp_pending,
  output logic [NUM_WARPS-1:0]                warp_full,
  input  logic [NW_WIDTH-1:0]                 csr_read_wid,
  input  logic [PID_WIDTH-1:0]                csr_read_pid,
  input  logic [CSR_ADDR_BITS-1:0]            csr_read_addr,
  output logic [NUM_LANES-1:0][XLEN-1:0]      csr_read_data
);

  localparam int SLOT_W  = log2up(DEPTH);
  localparam int CNT_W   = $clog2(DEPTH + 1);
  localparam int ENTRIES = NUM_WARPS * DEPTH;
  localparam int ADDR_W  = log2up(ENTRIES);

  logic [NUM_WARPS-1:0][SLOT_W-1:0] head;
  logic [NUM_WARPS-1:0][SLOT_W-1:0] tail;
  logic                             write_fire;
  logic [ADDR_W-1:0]                write_addr;
  logic [ADDR_W-1:0]                read_addr;
  logic [RASTER_CSR_SEL_BITS-1:0]   read_sel;
  raster_csrs_t                     thread_rd [NUM_THREADS];
  logic                             unused_bits;

  // Readiness follows the registered count only; a same-cycle pop does not free the slot early.
  assign write_ready = !warp_full[write_wid];
  assign write_fire  = write_valid && write_ready;
  assign write_addr  = ADDR_W'(int'(write_wid) * DEPTH + int'(tail[write_wid]));
  assign read_addr   = ADDR_W'(int'(csr_read_wid) * DEPTH + int'(head[csr_read_wid]));
  assign read_sel    = csr_read_addr[RASTER_CSR_SEL_BITS-1:0];
  assign unused_bits = ^{write_uuid, csr_read_addr[CSR_ADDR_BITS-1:RASTER_CSR_SEL_BITS]};

  for (genvar gi = 0; gi < NUM_WARPS; gi++) begin : g_warp
    logic commit;
    logic pop;
    assign commit = write_fire && write_last && (write_wid == NW_WIDTH'(gi));
    assign pop    = pop_valid && (pop_wid == NW_WIDTH'(gi));

    vx_raster_stamp_queue_ptrs #(
      .DEPTH  (DEPTH),
      .SLOT_W (SLOT_W),
      .CNT_W  (CNT_W)
    ) u_ptrs (
      .clk     (clk),
      .reset   (reset),
      .commit  (commit),
      .pop     (pop),
      .head    (head[gi]),
      .tail    (tail[gi]),
      .pending (warp_pending[gi]),
      .full    (warp_full[gi])
    );
  end

  // One distributed RAM per thread, addressed by {warp, slot}; contents are never reset.
  for (genvar gi = 0; gi < NUM_THREADS; gi++) begin : g_thread
    localparam int LANE = gi % NUM_LANES;
    localparam int PID  = gi / NUM_LANES;
    raster_csrs_t ram [ENTRIES];

    always_ff @(posedge clk) begin
      if (write_fire && (write_pid == PID_WIDTH'(PID)))
        ram[write_addr] <= write_tmask[LANE] ? to_csrs(write_data[LANE]) : '0;
    end

    assign thread_rd[gi] = ram[read_addr];
  end

  always_comb begin
    csr_read_data = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (warp_pending[csr_read_wid])
        csr_read_data[i] = XLEN'(csr_word(thread_rd[int'(csr_read_pid) * NUM_LANES + i], read_sel));
    end
  end

  always @(posedge clk) begin
    if (!reset && pop_valid)
      assert (warp_pending[pop_wid])
      else $warning("raster stamp queue %0d: pop on empty warp %0d ignored", CORE_ID, pop_wid);
  end

endmodule

// File: tb/tb_vx_raster_stamp_queue.sv
// Directed bench for the raster stamp queue: four lanes, four threads, four warps, two slots per warp.
module tb_vx_raster_stamp_queue;
  import vx_raster_stamp_queue_pkg::*;

  logic                     clk;
  logic                     reset;
  logic                     write_valid;
  logic                     write_ready;
  logic [UUID_WIDTH-1:0]    write_uuid;
  logic [1:0]               write_wid;
  logic [0:0]               write_pid;
  logic [3:0]               write_tmask;
  raster_stamp_t [3:0]      write_data;
  logic                     write_last;
  logic                     pop_valid;
  logic [1:0]               pop_wid;
  logic [3:0]               warp_pending;
  logic [3:0]               warp_full;
  logic [1:0]               csr_read_wid;
  logic [0:0]               csr_read_pid;
  logic [CSR_ADDR_BITS-1:0] csr_read_addr;
  logic [3:0][XLEN-1:0]     csr_read_data;

  int n_cmp = 0;
  int n_bad = 0;

  vx_raster_stamp_queue #(
    .CORE_ID     (0),
    .NUM_LANES   (4),
    .NUM_WARPS   (4),
    .NUM_THREADS (4),
    .DEPTH       (2),
    .PID_WIDTH   (1),
    .NW_WIDTH    (2)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .write_valid   (write_valid),
    .write_ready   (write_ready),
    .write_uuid    (write_uuid),
    .write_wid     (write_wid),
    .write_pid     (write_pid),
    .write_tmask   (write_tmask),
    .write_data    (write_data),
    .write_last    (write_last),
    .pop_valid     (pop_valid),
    .pop_wid       (pop_wid),
    .warp_pending  (warp_pending),
    .warp_full     (warp_full),
    .csr_read_wid  (csr_read_wid),
    .csr_read_pid  (csr_read_pid),
    .csr_read_addr (csr_read_addr),
    .csr_read_data (csr_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] pm(input int x, input int y, input logic [3:0] m);
    return 32'((y << 18) | (x << 4) | int'(m));
  endfunction

  function automatic logic [31:0] bc(input int base, input int lane);
    return 32'hB000_0000 + 32'(base * 16 + lane);
  endfunction

  function automatic raster_stamp_t mk(input int x, input int y, input logic [31:0] b);
    raster_stamp_t s;
    s = '0;
    s.pos_x = 14'(x);
    s.pos_y = 14'(y);
    s.mask  = 4'hF;
    s.bcoords[0][0] = b;
    s.bcoords[2][3] = ~b;
    return s;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_write(input int wid, input logic [3:0] tmask, input int base, input logic last);
    write_valid = 1'b1;
    write_wid   = 2'(wid);
    write_pid   = '0;
    write_tmask = tmask;
    write_last  = last;
    write_uuid  = UUID_WIDTH'(base);
    for (int i = 0; i < 4; i++) write_data[i] = mk(base + i, 5, bc(base, i));
  endtask

  task automatic push(input int wid, input logic [3:0] tmask, input int base, input logic last);
    drive_write(wid, tmask, base, last);
    $display("push wid=%0d tmask=%b base=%0d last=%0d", wid, tmask, base, last);
    tick();
    write_valid = 1'b0;
    write_last  = 1'b0;
  endtask

  task automatic pop(input int wid);
    pop_valid = 1'b1;
    pop_wid   = 2'(wid);
    $display("pop  wid=%0d", wid);
    tick();
    pop_valid = 1'b0;
  endtask

  task automatic rd(input int wid, input int addr);
    csr_read_wid  = 2'(wid);
    csr_read_pid  = '0;
    csr_read_addr = CSR_ADDR_BITS'(addr);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    write_valid = 0; write_uuid = '0; write_wid = '0; write_pid = '0;
    write_tmask = '0; write_data = '0; write_last = 0;
    pop_valid = 0; pop_wid = '0;
    csr_read_wid = '0; csr_read_pid = '0; csr_read_addr = '0;
    #1;
    chk("reset_pending", 32'(warp_pending), 32'h0);
    chk("reset_full", 32'(warp_full), 32'h0);
    chk("reset_ready", 32'(write_ready), 32'h1);
    chk("reset_rdata", csr_read_data[0], 32'h0);
    @(negedge clk);
    reset = 1'b0;
    tick();

    // Single batch to warp 1
    push(1, 4'hF, 3, 1'b1);
    chk("w1_pending", 32'(warp_pending), 32'h2);
    rd(1, 0);
    chk("w1_pm_lane0", csr_read_data[0], 32'h0014_003F);
    chk("w1_pm_lane3", csr_read_data[3], 32'h0014_006F);
    rd(1, 1);
    chk("w1_bc_lane2", csr_read_data[2], 32'hB000_0032);
    rd(1, 12);
    chk("w1_bc23_lane1", csr_read_data[1], ~32'hB000_0031);
    rd(1, 14);
    chk("w1_unused_word", csr_read_data[0], 32'h0);
    pop(1);
    rd(1, 0);
    chk("w1_empty_pending", 32'(warp_pending), 32'h0);
    chk("w1_empty_rdata", csr_read_data[0], 32'h0);

    // Fill warp 0, offer a third batch while popping
    push(0, 4'hF, 16, 1'b1);
    chk("w0_one_full", 32'(warp_full), 32'h0);
    push(0, 4'hF, 32, 1'b1);
    chk("w0_full", 32'(warp_full), 32'h1);
    drive_write(0, 4'hF, 48, 1'b1);
    #1;
    chk("w0_ready_low", 32'(write_ready), 32'h0);
    pop_valid = 1'b1;
    pop_wid   = 2'd0;
    $display("offer wid=0 base=48 with pop wid=0");
    tick();
    pop_valid = 1'b0;
    chk("w0_ready_after_pop", 32'(write_ready), 32'h1);
    write_valid = 1'b0;
    write_last  = 1'b0;
    rd(0, 0);
    chk("w0_second_stamp", csr_read_data[0], 32'h0014_020F);
    chk("w0_not_full", 32'(warp_full), 32'h0);

    // Commit and pop together with one slot held
    pop_valid = 1'b1;
    pop_wid   = 2'd0;
    push(0, 4'hF, 64, 1'b1);
    pop_valid = 1'b0;
    rd(0, 0);
    chk("w0_cp_pending", 32'(warp_pending), 32'h1);
    chk("w0_cp_full", 32'(warp_full), 32'h0);
    chk("w0_cp_head", csr_read_data[0], 32'h0014_040F);
    pop(0);
    chk("w0_cp_drained", 32'(warp_pending), 32'h0);

    // Partial lane mask
    push(2, 4'b0101, 80, 1'b1);
    rd(2, 0);
    chk("tm_lane0", csr_read_data[0], 32'h0014_050F);
    chk("tm_lane1", csr_read_data[1], 32'h0);
    chk("tm_lane2", csr_read_data[2], 32'h0014_052F);
    chk("tm_lane3", csr_read_data[3], 32'h0);
    pop(2);

    // Pop on an empty warp is dropped
    pop(3);
    write_wid = 2'd3;
    #1;
    chk("empty_pop_pending", 32'(warp_pending), 32'h0);
    chk("empty_pop_full", 32'(warp_full), 32'h0);
    chk("empty_pop_ready", 32'(write_ready), 32'h1);

    // Pointer wrap over DEPTH+1 commit/pop pairs
    for (int k = 0; k < 3; k++) begin
      push(3, 4'hF, 100 + 16 * k, 1'b1);
      rd(3, 0);
      chk($sformatf("wrap%0d_lane1", k), csr_read_data[1], pm(101 + 16 * k, 5, 4'hF));
      rd(3, 1);
      chk($sformatf("wrap%0d_bc3", k), csr_read_data[3], bc(100 + 16 * k, 3));
      pop(3);
      chk($sformatf("wrap%0d_drained", k), 32'(warp_pending), 32'h0);
    end

    // Asynchronous reset in the middle of a batch
    push(1, 4'hF, 200, 1'b1);
    push(1, 4'hF, 216, 1'b0);
    chk("mid_pending_before", 32'(warp_pending), 32'h2);
    reset = 1'b1;
    #1;
    chk("mid_pending_async", 32'(warp_pending), 32'h0);
    @(negedge clk);
    reset = 1'b0;
    tick();
    push(1, 4'hF, 224, 1'b1);
    rd(1, 0);
    chk("post_reset_pending", 32'(warp_pending), 32'h2);
    chk("post_reset_lane0", csr_read_data[0], 32'h0014_0E0F);
    rd(1, 1);
    chk("post_reset_bc1", csr_read_data[1], 32'hB000_0E01);
    pop(1);
    push(1, 4'hF, 240, 1'b1);
    rd(1, 0);
    chk("post_reset_slot1", csr_read_data[2], pm(242, 5, 4'hF));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
